// File: rtl/fir_pkg.sv
// Shared widths and loader state encoding for the FIR
// coefficient path; imported by RTL and bench alike.
package fir_pkg;

  localparam int COEF_W   = 8;
  localparam int NUM_TAPS = 4;
  localparam int SHIFT_W  = NUM_TAPS * COEF_W;
  localparam int CNT_W    = $clog2(SHIFT_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PH1,
    GAP1,
    PH2,
    GAP2,
    DONE
  } loader_state_t;

  // Counter width for a phase length; at least one bit so
  // a single-cycle phase still has a real register.
  function automatic int timer_w(input int pc);
    return (pc > 1) ? $clog2(pc) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_loader_phase_timer.sv
// Phase length timer: reloads on each state change and
// flags the last clock of the current phase.
module phase_timer
  import fir_pkg::*;
#(
  parameter int PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic expire_o
);

  localparam int W = timer_w(PHASE_CYCLES);
  localparam logic [W-1:0] RELOAD = W'(PHASE_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload on entry to a phase, otherwise count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient loader: accepts a packed tap set and shifts
// it MSB-first onto the two-phase scan chain.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int PHASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coef_valid,
  output logic               coef_ready,
  input  logic [SHIFT_W-1:0] coefs,
  output logic               shiftIn,
  output logic               shiftClk1,
  output logic               shiftClk2,
  output logic               busy,
  output logic               done
);

  loader_state_t      state_q, state_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic               sin_q, sin_d;
  logic               sc1_q, sc1_d;
  logic               sc2_q, sc2_d;
  logic               done_q, done_d;
  logic               expire;
  logic               accept;

  assign coef_ready = (state_q == IDLE) && !reset;
  assign accept     = coef_valid && coef_ready;
  assign busy       = (state_q != IDLE) && (state_q != DONE);

  phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_d != state_q),
    .expire_o (expire)
  );

  // Next state, shift register, bit counter and the
  // registered versions of the chain-facing outputs.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          shreg_d = coefs;
          bit_d   = '0;
        end
      end
      SETUP: if (expire) state_d = PH1;
      PH1:   if (expire) state_d = GAP1;
      GAP1:  if (expire) state_d = PH2;
      PH2:   if (expire) state_d = GAP2;
      GAP2: begin
        if (expire) begin
          shreg_d = {shreg_q[SHIFT_W-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (bit_q == CNT_W'(SHIFT_W - 1)) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sin_d = sin_q;
    if (state_d == SETUP && state_q != SETUP) begin
      sin_d = shreg_d[SHIFT_W-1];
    end
    sc1_d  = (state_d == PH1);
    sc2_d  = (state_d == PH2);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      sin_q   <= 1'b0;
      sc1_q   <= 1'b0;
      sc2_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      sin_q   <= sin_d;
      sc1_q   <= sc1_d;
      sc2_q   <= sc2_d;
      done_q  <= done_d;
    end
  end

  assign shiftIn   = sin_q;
  assign shiftClk1 = sc1_q;
  assign shiftClk2 = sc2_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: two instances (2- and
// 1-cycle phases), scan-chain model and stream scoreboard.
module tb_fir_coef_loader;
  import fir_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset[2];
  logic               coef_valid[2];
  logic               coef_ready[2];
  logic [SHIFT_W-1:0] coefs[2];
  logic               shiftIn[2];
  logic               sc1[2];
  logic               sc2[2];
  logic               busy[2];
  logic               done[2];

  int compared   = 0;
  int mismatched = 0;
  int viol       = 0;
  int cyc        = 0;

  bit                 exp_q[2][$];
  int                 p1cnt[2];
  int                 p2cnt[2];
  logic [SHIFT_W-1:0] chain[2];
  logic               master[2];
  logic [SHIFT_W-1:0] saved_taps;

  fir_coef_loader #(.PHASE_CYCLES(2)) dut0 (
    .clk        (clk),
    .reset      (reset[0]),
    .coef_valid (coef_valid[0]),
    .coef_ready (coef_ready[0]),
    .coefs      (coefs[0]),
    .shiftIn    (shiftIn[0]),
    .shiftClk1  (sc1[0]),
    .shiftClk2  (sc2[0]),
    .busy       (busy[0]),
    .done       (done[0])
  );

  fir_coef_loader #(.PHASE_CYCLES(1)) dut1 (
    .clk        (clk),
    .reset      (reset[1]),
    .coef_valid (coef_valid[1]),
    .coef_ready (coef_ready[1]),
    .coefs      (coefs[1]),
    .shiftIn    (shiftIn[1]),
    .shiftClk1  (sc1[1]),
    .shiftClk2  (sc2[1]),
    .busy       (busy[1]),
    .done       (done[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance monitor: chain model, stream scoreboard,
  // non-overlap / setup-hold / low-gap invariants.
  for (genvar k = 0; k < 2; k++) begin : g_mon
    localparam int PC = (k == 0) ? 2 : 1;
    int   lowcnt = 0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    logic pin = 1'b0;
    bit   e;
    always @(negedge clk) begin
      if (reset[k]) begin
        lowcnt = 0;
        p1 = 1'b0;
        p2 = 1'b0;
        pin = 1'b0;
      end else begin
        if (sc1[k] && sc2[k]) begin
          viol++;
          $display("FAIL overlap[%0d]: clk1=1 clk2=1, required never both", k);
        end
        if ((sc1[k] || sc2[k]) && shiftIn[k] !== pin) begin
          viol++;
          $display("FAIL sin_hold[%0d]: got %b, required %b", k, shiftIn[k], pin);
        end
        if (sc1[k] && !p1) begin
          compared++;
          if (lowcnt < PC) begin
            mismatched++;
            $display("FAIL gap1[%0d]: low cycles %0d, required >=%0d", k, lowcnt, PC);
          end
          compared++;
          if (exp_q[k].size() == 0) begin
            mismatched++;
            $display("FAIL stream[%0d]: unexpected pulse, got %b required none", k, shiftIn[k]);
          end else begin
            e = exp_q[k].pop_front();
            if (shiftIn[k] !== e) begin
              mismatched++;
              $display("FAIL stream[%0d]: got %b, required %b", k, shiftIn[k], e);
            end
          end
          master[k] = shiftIn[k];
          p1cnt[k]++;
        end
        if (sc2[k] && !p2) begin
          compared++;
          if (lowcnt < PC) begin
            mismatched++;
            $display("FAIL gap2[%0d]: low cycles %0d, required >=%0d", k, lowcnt, PC);
          end
          chain[k] = {chain[k][SHIFT_W-2:0], master[k]};
          p2cnt[k]++;
        end
        lowcnt = (!sc1[k] && !sc2[k]) ? lowcnt + 1 : 0;
        p1  = sc1[k];
        p2  = sc2[k];
        pin = shiftIn[k];
      end
    end
  end

  task automatic start_load(input int k, input logic [31:0] w,
                            output int t, output int b1, output int b2);
    int n;
    for (int i = SHIFT_W - 1; i >= 0; i--) exp_q[k].push_back(w[i]);
    @(negedge clk);
    coef_valid[k] = 1'b1;
    coefs[k] = w;
    n = 0;
    while (!coef_ready[k] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 1000) begin
      mismatched++;
      $display("FAIL ready_wait[%0d]: coef_ready 0, required 1 within 1000", k);
    end
    b1 = p1cnt[k];
    b2 = p2cnt[k];
    @(negedge clk);
    t = cyc;
    coef_valid[k] = 1'b0;
  endtask

  task automatic finish_load(input int k, input logic [31:0] w,
                             input int t, input int b1, input int b2);
    int pc = (k == 0) ? 2 : 1;
    int n = 0;
    while (!done[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (cyc !== t + 5 * pc * SHIFT_W) begin
      mismatched++;
      $display("FAIL done_time[%0d]: got %0d, required %0d", k, cyc - t, 5 * pc * SHIFT_W);
    end
    compared++;
    if (p1cnt[k] - b1 !== SHIFT_W || p2cnt[k] - b2 !== SHIFT_W) begin
      mismatched++;
      $display("FAIL pulses[%0d]: got %0d/%0d, required %0d", k,
               p1cnt[k] - b1, p2cnt[k] - b2, SHIFT_W);
    end
    compared++;
    if (chain[k] !== w) begin
      mismatched++;
      $display("FAIL chain[%0d]: got %h, required %h", k, chain[k], w);
    end
    @(negedge clk);
    compared++;
    if (coef_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_after[%0d]: got rdy=%b busy=%b, required 1/0", k,
               coef_ready[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      coef_valid[k] = 1'b0;
      coefs[k] = '0;
      p1cnt[k] = 0;
      p2cnt[k] = 0;
      chain[k] = '0;
      master[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if ({coef_ready[k], shiftIn[k], sc1[k], sc2[k], busy[k], done[k]} !== 6'b0) begin
        mismatched++;
        $display("FAIL in_reset[%0d]: got %b, required 000000", k,
                 {coef_ready[k], shiftIn[k], sc1[k], sc2[k], busy[k], done[k]});
      end
    end
    #18;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if ({coef_ready[k], shiftIn[k], sc1[k], sc2[k], busy[k], done[k]} !== 6'b100000) begin
        mismatched++;
        $display("FAIL post_reset[%0d]: got %b, required 100000", k,
                 {coef_ready[k], shiftIn[k], sc1[k], sc2[k], busy[k], done[k]});
      end
    end
    repeat (100) @(negedge clk);
    compared++;
    if (p1cnt[0] + p2cnt[0] + p1cnt[1] + p2cnt[1] !== 0 || busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_quiet: got %0d pulses busy=%b, required 0/0",
               p1cnt[0] + p2cnt[0] + p1cnt[1] + p2cnt[1], busy[0]);
    end
  endtask

  task automatic test_single_load();
    int t, b1, b2;
    start_load(0, 32'h04_03_02_01, t, b1, b2);
    finish_load(0, 32'h04_03_02_01, t, b1, b2);
    saved_taps = chain[0];
    for (int i = 0; i < NUM_TAPS; i++) begin
      compared++;
      if (chain[0][i*COEF_W +: COEF_W] !== COEF_W'(i + 1)) begin
        mismatched++;
        $display("FAIL tap_c%0d: got %0d, required %0d", i,
                 chain[0][i*COEF_W +: COEF_W], i + 1);
      end
    end
  endtask

  task automatic test_fir();
    int a[4];
    int h[4];
    int y;
    a = '{1, 2, 3, 4};
    h = '{0, 0, 0, 0};
    y = 0;
    for (int n = 0; n < 4; n++) begin
      h[3] = h[2];
      h[2] = h[1];
      h[1] = h[0];
      h[0] = a[n];
      y = 0;
      for (int i = 0; i < NUM_TAPS; i++)
        y += int'(saved_taps[i*COEF_W +: COEF_W]) * h[i];
      y = y >>> 2;
    end
    compared++;
    if (y !== 5) begin
      mismatched++;
      $display("FAIL fir_y4: got %0d, required 5", y);
    end
  endtask

  task automatic test_back_to_back();
    int t, b1, b2, n, rdy_hi;
    start_load(0, 32'h11_22_33_44, t, b1, b2);
    repeat (50) @(negedge clk);
    for (int i = SHIFT_W - 1; i >= 0; i--) exp_q[0].push_back(1'b1);
    coef_valid[0] = 1'b1;
    coefs[0] = 32'hFFFF_FFFF;
    n = 0;
    rdy_hi = 0;
    while (!done[0] && n < 2000) begin
      if (coef_ready[0]) rdy_hi++;
      @(negedge clk);
      n++;
    end
    compared++;
    if (rdy_hi !== 0) begin
      mismatched++;
      $display("FAIL busy_ready: got %0d ready cycles, required 0", rdy_hi);
    end
    compared++;
    if (cyc !== t + 10 * SHIFT_W) begin
      mismatched++;
      $display("FAIL b2b_done_time: got %0d, required %0d", cyc - t, 10 * SHIFT_W);
    end
    compared++;
    if (chain[0] !== 32'h11_22_33_44 || p1cnt[0] - b1 !== SHIFT_W) begin
      mismatched++;
      $display("FAIL b2b_first: got %h/%0d, required 11223344/32",
               chain[0], p1cnt[0] - b1);
    end
    @(negedge clk);
    compared++;
    if (coef_ready[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ready: got %b, required 1", coef_ready[0]);
    end
    b1 = p1cnt[0];
    b2 = p2cnt[0];
    @(negedge clk);
    t = cyc;
    compared++;
    if (busy[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_restart: busy got %b, required 1", busy[0]);
    end
    coef_valid[0] = 1'b0;
    finish_load(0, 32'hFFFF_FFFF, t, b1, b2);
  endtask

  task automatic test_reset_mid();
    int t, b1, b2, n;
    start_load(0, 32'hDEAD_BEEF, t, b1, b2);
    n = 0;
    while (p1cnt[0] - b1 < 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2;
    reset[0] = 1'b1;
    #1;
    compared++;
    if ({coef_ready[0], shiftIn[0], sc1[0], sc2[0], busy[0], done[0]} !== 6'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got %b, required 000000",
               {coef_ready[0], shiftIn[0], sc1[0], sc2[0], busy[0], done[0]});
    end
    exp_q[0].delete();
    @(negedge clk);
    reset[0] = 1'b0;
    start_load(0, 32'hA5_5A_C3_3C, t, b1, b2);
    finish_load(0, 32'hA5_5A_C3_3C, t, b1, b2);
  endtask

  task automatic test_phase1();
    int t, b1, b2;
    start_load(1, 32'h04_03_02_01, t, b1, b2);
    finish_load(1, 32'h04_03_02_01, t, b1, b2);
  endtask

  task automatic test_invariants();
    compared++;
    if (viol !== 0 || exp_q[0].size() !== 0 || exp_q[1].size() !== 0) begin
      mismatched++;
      $display("FAIL invariants: got %0d violations %0d/%0d leftover, required 0",
               viol, exp_q[0].size(), exp_q[1].size());
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_fir();
    test_back_to_back();
    test_reset_mid();
    test_phase1();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
